divider_64b_seq: RTL and testbench

DIVIDER_64B_SEQ -- requirements
Module: divider_64b_seq

---
 rtl/divider_64b_seq.sv | 103 ++++++++++
 tb/tb_divider_64b_seq.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/divider_64b_seq.sv
// rtl/divider_64b_seq.sv - sequential 2*DW / DW unsigned restoring divider
// One quotient bit per enabled edge; a zero divisor short-circuits to DONE with all-ones quotient.
module divider_64b_seq #(
  parameter int DW = 32
) (
  input  logic            iClk,
  input  logic            iRst,
  input  logic            iEn,
  input  logic            iClr,
  input  logic            iValid,
  output logic            oReady,
  input  logic [2*DW-1:0] iData,
  input  logic [DW-1:0]   iDivisor,
  output logic            oValid,
  input  logic            iReady,
  output logic [2*DW-1:0] oQuot,
  output logic [DW-1:0]   oRem,
  output logic            oDivByZero
);

  localparam int CW = $clog2(2*DW+1);

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

  state_t          r_state;
  logic [2*DW-1:0] r_dvd;
  logic [DW-1:0]   r_dvs;
  logic [DW:0]     r_rem;
  logic [CW-1:0]   r_cnt;

  logic [DW:0]     w_shift;
  logic [DW:0]     w_diff;
  logic            w_ge;

  // Dividend register doubles as the quotient: its MSB feeds the remainder, quotient bits enter at the LSB.
  assign w_shift = {r_rem[DW-1:0], r_dvd[2*DW-1]};
  assign w_diff  = w_shift - {1'b0, r_dvs};
  assign w_ge    = r_rem[DW] | (w_shift >= {1'b0, r_dvs});

  always_ff @(posedge iClk) begin
    if (iRst || iClr) begin
      r_state    <= S_IDLE;
      r_dvd      <= '0;
      r_dvs      <= '0;
      r_rem      <= '0;
      r_cnt      <= '0;
      oReady     <= 1'b1;
      oValid     <= 1'b0;
      oQuot      <= '0;
      oRem       <= '0;
      oDivByZero <= 1'b0;
    end else if (iEn) begin
      case (r_state)
        S_IDLE: begin
          if (iValid && oReady) begin
            r_dvd   <= iData;
            r_dvs   <= iDivisor;
            r_rem   <= '0;
            r_cnt   <= '0;
            oReady  <= 1'b0;
            r_state <= S_BUSY;
          end
        end
        S_BUSY: begin
          if (r_dvs == '0) begin
            oQuot      <= '1;
            oRem       <= r_dvd[DW-1:0];
            oDivByZero <= 1'b1;
            oValid     <= 1'b1;
            r_state    <= S_DONE;
          end else if (r_cnt == CW'(2*DW)) begin
            oQuot      <= r_dvd;
            oRem       <= r_rem[DW-1:0];
            oDivByZero <= 1'b0;
            oValid     <= 1'b1;
            r_state    <= S_DONE;
          end else begin
            r_rem <= w_ge ? w_diff : w_shift;
            r_dvd <= {r_dvd[2*DW-2:0], w_ge};
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_DONE: begin
          // Handshake returns to IDLE only; the next accept waits for the following edge.
          if (iReady) begin
            oValid     <= 1'b0;
            oQuot      <= '0;
            oRem       <= '0;
            oDivByZero <= 1'b0;
            oReady     <= 1'b1;
            r_state    <= S_IDLE;
          end
        end
        default: begin
          r_state <= S_IDLE;
          oReady  <= 1'b1;
          oValid  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_divider_64b_seq.sv
// tb/tb_divider_64b_seq.sv - directed self-checking bench for divider_64b_seq
module tb_divider_64b_seq;

  localparam int DW = 32;

  logic          iClk = 1'b0;
  logic          iRst = 1'b1;
  logic          iEn = 1'b0;
  logic          iClr = 1'b0;
  logic          iValid = 1'b0;
  logic          oReady;
  logic [63:0]   iData = '0;
  logic [31:0]   iDivisor = '0;
  logic          oValid;
  logic          iReady = 1'b0;
  logic [63:0]   oQuot;
  logic [31:0]   oRem;
  logic          oDivByZero;

  int checks = 0;
  int errors = 0;
  logic run_cmp = 1'b0;

  logic [63:0] exp_q;
  logic [31:0] exp_r;
  logic        exp_dz;

  divider_64b_seq #(.DW(DW)) dut (
    .iClk(iClk), .iRst(iRst), .iEn(iEn), .iClr(iClr), .iValid(iValid), .oReady(oReady),
    .iData(iData), .iDivisor(iDivisor), .oValid(oValid), .iReady(iReady),
    .oQuot(oQuot), .oRem(oRem), .oDivByZero(oDivByZero)
  );

  always #5 iClk = ~iClk;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, want);
    end
  endtask

  function automatic void model(input logic [63:0] a, input logic [31:0] d,
                                output logic [63:0] q, output logic [31:0] r, output logic dz);
    dz = (d == 32'd0);
    if (dz) begin
      q = '1;
      r = a[31:0];
    end else begin
      q = a / {32'd0, d};
      r = 32'(a % {32'd0, d});
    end
  endfunction

  always @(negedge iClk) begin
    if (run_cmp) begin
      chk("ready_valid_exclusive", {63'd0, oReady & oValid}, 64'd0);
      if (oValid) begin
        chk("cmp_quot", oQuot, exp_q);
        chk("cmp_rem", {32'd0, oRem}, {32'd0, exp_r});
        chk("cmp_dz", {63'd0, oDivByZero}, {63'd0, exp_dz});
      end else begin
        chk("cmp_quot_zero", oQuot, 64'd0);
        chk("cmp_rem_zero", {32'd0, oRem}, 64'd0);
        chk("cmp_dz_zero", {63'd0, oDivByZero}, 64'd0);
      end
    end
  end

  task automatic check_reset_values(input string tag);
    chk({tag, "_ready"}, {63'd0, oReady}, 64'd1);
    chk({tag, "_valid"}, {63'd0, oValid}, 64'd0);
    chk({tag, "_quot"}, oQuot, 64'd0);
    chk({tag, "_rem"}, {32'd0, oRem}, 64'd0);
    chk({tag, "_dz"}, {63'd0, oDivByZero}, 64'd0);
  endtask

  task automatic start_op(input logic [63:0] a, input logic [31:0] d);
    @(negedge iClk);
    chk("ready_before_accept", {63'd0, oReady}, 64'd1);
    model(a, d, exp_q, exp_r, exp_dz);
    iData = a;
    iDivisor = d;
    iValid = 1'b1;
    iEn = 1'b1;
    @(posedge iClk);
    #1;
    // Operands change and iValid stays high while the result is in flight.
    iData = ~a;
    iDivisor = d + 32'd3;
    chk("ready_low_after_accept", {63'd0, oReady}, 64'd0);
  endtask

  task automatic wait_done(input int stall_at, input int stall_len, input int exp_lat);
    int lat;
    lat = -1;
    for (int cyc = 1; cyc <= 200; cyc++) begin
      iEn = (cyc > stall_at && cyc <= stall_at + stall_len) ? 1'b0 : 1'b1;
      @(posedge iClk);
      #1;
      if (oValid) begin
        lat = cyc;
        break;
      end
    end
    iEn = 1'b1;
    chk("latency", 64'(lat), 64'(exp_lat));
  endtask

  task automatic finish_op(input logic [63:0] q_lit, input logic [31:0] r_lit, input logic dz_lit,
                           input int ready_delay);
    chk("lit_quot", oQuot, q_lit);
    chk("lit_rem", {32'd0, oRem}, {32'd0, r_lit});
    chk("lit_dz", {63'd0, oDivByZero}, {63'd0, dz_lit});
    for (int i = 0; i < ready_delay; i++) begin
      @(posedge iClk);
      #1;
      chk("hold_valid", {63'd0, oValid}, 64'd1);
      chk("hold_quot", oQuot, q_lit);
      chk("hold_rem", {32'd0, oRem}, {32'd0, r_lit});
    end
    iReady = 1'b1;
    @(posedge iClk);
    #1;
    iReady = 1'b0;
    chk("post_hs_valid", {63'd0, oValid}, 64'd0);
    chk("post_hs_ready", {63'd0, oReady}, 64'd1);
    iValid = 1'b0;
  endtask

  task automatic run_op(input logic [63:0] a, input logic [31:0] d, input int stall_at,
                        input int stall_len, input int lat, input logic [63:0] q_lit,
                        input logic [31:0] r_lit, input logic dz_lit, input int ready_delay);
    start_op(a, d);
    wait_done(stall_at, stall_len, lat);
    finish_op(q_lit, r_lit, dz_lit, ready_delay);
  endtask

  initial begin
    logic [63:0] mq;
    logic [31:0] mr;
    logic        mdz;
    int          seen_valid;

    model(64'd200, 32'd20, mq, mr, mdz);
    chk("model_200_20_q", mq, 64'd10);
    chk("model_200_20_r", {32'd0, mr}, 64'd0);
    model(64'hFFFF_FFFF_FFFF_FFFF, 32'hFFFF_FFFF, mq, mr, mdz);
    chk("model_max_q", mq, 64'h1_0000_0001);
    model(64'd1000, 32'd7, mq, mr, mdz);
    chk("model_1000_7_r", {32'd0, mr}, 64'd6);

    repeat (2) @(posedge iClk);
    #1;
    check_reset_values("reset");
    iRst = 1'b0;
    iEn = 1'b1;
    run_cmp = 1'b1;

    run_op(64'd200, 32'd20, 0, 0, 65, 64'd10, 32'd0, 1'b0, 0);
    run_op(64'hFFFF_FFFF_FFFF_FFFF, 32'hFFFF_FFFF, 0, 0, 65, 64'h1_0000_0001, 32'd0, 1'b0, 0);
    run_op(64'd1000, 32'd7, 0, 0, 65, 64'd142, 32'd6, 1'b0, 0);
    run_op(64'h1234_5678_9ABC_DEF0, 32'd0, 0, 0, 1, 64'hFFFF_FFFF_FFFF_FFFF, 32'h9ABC_DEF0, 1'b1, 0);
    run_op(64'd1000, 32'd7, 20, 10, 75, 64'd142, 32'd6, 1'b0, 0);
    run_op(64'd200, 32'd20, 0, 0, 65, 64'd10, 32'd0, 1'b0, 5);
    run_op(64'hFFFF_FFFF_FFFF_FFFF, 32'd1, 0, 0, 65, 64'hFFFF_FFFF_FFFF_FFFF, 32'd0, 1'b0, 0);
    run_op(64'd5, 32'd9, 0, 0, 65, 64'd0, 32'd5, 1'b0, 0);

    start_op(64'd200, 32'd20);
    repeat (30) @(posedge iClk);
    #1;
    iClr = 1'b1;
    @(posedge iClk);
    #1;
    iClr = 1'b0;
    iValid = 1'b0;
    check_reset_values("clear");
    seen_valid = 0;
    for (int i = 0; i < 80; i++) begin
      @(posedge iClk);
      #1;
      if (oValid) seen_valid++;
    end
    chk("clear_discards_result", 64'(seen_valid), 64'd0);

    start_op(64'd1000, 32'd7);
    wait_done(0, 0, 65);
    chk("pre_rst_quot", oQuot, 64'd142);
    iEn = 1'b0;
    iRst = 1'b1;
    @(posedge iClk);
    #1;
    iRst = 1'b0;
    iEn = 1'b1;
    iValid = 1'b0;
    check_reset_values("rst_in_done");
    run_op(64'd200, 32'd20, 0, 0, 65, 64'd10, 32'd0, 1'b0, 0);

    run_cmp = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
